// File: rtl/mcu_bus_regfile_if.sv
// Control and address pins of the multiplexed MCU bus (ALE/CSbar/Rbar/Wbar/ABUS).
// DBUS is bidirectional and is carried as a separate inout pin on the slave.
interface mcu_bus_regfile_if #(
    parameter int ABUS_W = 8
);
    logic [ABUS_W-1:0] ABUS;
    logic              CSbar;
    logic              ALE;
    logic              Rbar;
    logic              Wbar;

    modport master (output ABUS, CSbar, ALE, Rbar, Wbar);
    modport slave  (input  ABUS, CSbar, ALE, Rbar, Wbar);
endinterface

// File: rtl/mcu_bus_regfile.sv
// Parametrised register file slave for the multiplexed MCU bus.
// It supports read-back over a tristated DBUS, read-only status slots and a sticky bus-error flag.

module mcu_bus_regfile_slot #(
    parameter int                 DATA_W    = 8,
    parameter bit                 RO        = 1'b0,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] status,
    output logic [DATA_W-1:0] q
);
    logic [DATA_W-1:0] r;

    always_ff @(posedge clock) begin
        if (reset)   r <= RESET_VAL;
        else if (we) r <= wdata;
    end

    assign q = RO ? status : r;
endmodule

module mcu_bus_regfile #(
    parameter int                   DATA_W    = 8,
    parameter int                   ABUS_W    = 8,
    parameter int                   NUM_REGS  = 10,
    parameter int                   BASE_ADDR = 0,
    parameter logic [NUM_REGS-1:0]  RO_MASK   = '0,
    parameter logic [DATA_W-1:0]    RESET_VAL = '0,
    localparam int                  ADDR_W    = ABUS_W + DATA_W,
    localparam int                  IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    mcu_bus_regfile_if.slave             bus,
    inout  wire  [DATA_W-1:0]            DBUS,
    input  logic [NUM_REGS*DATA_W-1:0]   status_in,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic                         wr_strobe,
    output logic [IDX_W-1:0]             wr_index,
    output logic                         bus_err
);
    typedef enum logic [2:0] {IDLE, CAPTURE, ARMED, WR, RD} state_t;

    localparam logic [ADDR_W:0] BASE  = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

    state_t                          state;
    logic [ADDR_W-1:0]               addr;
    logic [DATA_W-1:0]               hold;
    logic                            r_prev, w_prev;
    logic [NUM_REGS-1:0][DATA_W-1:0] cur;
    logic [NUM_REGS-1:0]             we;
    logic [ADDR_W:0]                 off;
    logic [IDX_W-1:0]                idx;
    logic [DATA_W-1:0]               rd_val;
    logic                            in_range, ro_hit, w_fall, r_fall, commit, oe;

    // One extra bit catches addr < BASE_ADDR: the borrow makes off exceed NREGS.
    assign off      = {1'b0, addr} - BASE;
    assign in_range = off < NREGS;
    assign idx      = off[IDX_W-1:0];

    assign w_fall = w_prev && !bus.Wbar;
    assign r_fall = r_prev && !bus.Rbar;
    assign commit = (state == WR) && !bus.CSbar && bus.Wbar && in_range && !ro_hit;
    assign oe     = (state == RD) && !bus.CSbar && !bus.Rbar;
    assign DBUS   = oe ? rd_val : 'z;

    always_comb begin
        rd_val = '0;
        ro_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (in_range && idx == IDX_W'(i)) begin
                rd_val = cur[i];
                ro_hit = RO_MASK[i];
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
        assign we[i] = commit && (idx == IDX_W'(i));
        mcu_bus_regfile_slot #(
            .DATA_W(DATA_W), .RO(RO_MASK[i]), .RESET_VAL(RESET_VAL)
        ) u_slot (
            .clock(clock), .reset(reset), .we(we[i]), .wdata(hold),
            .status(status_in[i*DATA_W +: DATA_W]), .q(cur[i])
        );
        assign regs_out[i*DATA_W +: DATA_W] = cur[i];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            hold      <= '0;
            r_prev    <= 1'b1;
            w_prev    <= 1'b1;
            wr_strobe <= 1'b0;
            wr_index  <= '0;
            bus_err   <= 1'b0;
        end else begin
            r_prev    <= bus.Rbar;
            w_prev    <= bus.Wbar;
            wr_strobe <= 1'b0;
            if (bus.CSbar) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (bus.ALE) begin
                        state <= CAPTURE;
                        addr  <= {bus.ABUS, DBUS};
                    end
                    CAPTURE: if (bus.ALE) addr <= {bus.ABUS, DBUS};
                             else         state <= ARMED;
                    ARMED: begin
                        if (bus.ALE) begin
                            state <= CAPTURE;
                            addr  <= {bus.ABUS, DBUS};
                        end else if (w_fall && r_fall) begin
                            bus_err <= 1'b1;
                        end else if (w_fall) begin
                            state <= WR;
                            hold  <= DBUS;
                        end else if (r_fall) begin
                            state <= RD;
                            if (!in_range) bus_err <= 1'b1;
                        end
                    end
                    WR: begin
                        if (!bus.Wbar) begin
                            hold <= DBUS;
                        end else begin
                            // Register update itself happens in the slot via we[].
                            state <= ARMED;
                            if (commit) begin
                                wr_strobe <= 1'b1;
                                wr_index  <= idx;
                            end else begin
                                bus_err <= 1'b1;
                            end
                        end
                    end
                    RD: if (bus.Rbar) state <= ARMED;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mcu_bus_regfile.sv
// Bench for mcu_bus_regfile: two instances (all-writable, and slot 3 read-only) share one bus.
// Each instance is compared against a transaction-level register model.
module tb_mcu_bus_regfile;
    localparam int N = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mcu_bus_regfile_if #(.ABUS_W(8)) bus();

    wire  [7:0] dbus_a, dbus_b;
    logic       drv = 1'b0;
    logic [7:0] dout = '0;
    assign dbus_a = drv ? dout : 8'bz;
    assign dbus_b = drv ? dout : 8'bz;
    pullup (dbus_a);
    pullup (dbus_b);

    logic [N*8-1:0] status_a, status_b, regs_a, regs_b;
    logic           stb_a, stb_b, err_a, err_b;
    logic [3:0]     widx_a, widx_b;

    mcu_bus_regfile #(.DATA_W(8), .ABUS_W(8), .NUM_REGS(N), .BASE_ADDR(0),
                      .RO_MASK(10'h000), .RESET_VAL(8'h00)) dut_a (
        .clock(clk), .reset(rst), .bus(bus), .DBUS(dbus_a), .status_in(status_a),
        .regs_out(regs_a), .wr_strobe(stb_a), .wr_index(widx_a), .bus_err(err_a));

    mcu_bus_regfile #(.DATA_W(8), .ABUS_W(8), .NUM_REGS(N), .BASE_ADDR(0),
                      .RO_MASK(10'h008), .RESET_VAL(8'h00)) dut_b (
        .clock(clk), .reset(rst), .bus(bus), .DBUS(dbus_b), .status_in(status_b),
        .regs_out(regs_b), .wr_strobe(stb_b), .wr_index(widx_b), .bus_err(err_b));

    // Reference model: plain register arrays, error flags and strobe counts per instance.
    logic [7:0] mreg [2][N];
    bit         merr [2];
    logic [3:0] midx [2];
    int         mstb [2];
    int         seen_a = 0, seen_b = 0;
    int         vecs = 0, errs = 0;

    always @(negedge clk) begin
        if (stb_a === 1'b1) seen_a++;
        if (stb_b === 1'b1) seen_b++;
    end

    function automatic bit is_ro(int u, int i);
        return (u == 1) && (i == 3);
    endfunction

    function automatic logic [7:0] status_of(int u, int i);
        return (u == 0) ? status_a[i*8 +: 8] : status_b[i*8 +: 8];
    endfunction

    function automatic logic [N*8-1:0] exp_regs(int u);
        logic [N*8-1:0] v;
        for (int i = 0; i < N; i++) v[i*8 +: 8] = is_ro(u, i) ? status_of(u, i) : mreg[u][i];
        return v;
    endfunction

    function automatic logic [7:0] exp_read(int u, logic [15:0] a);
        if (a >= 16'(N)) return 8'h00;
        return is_ro(u, int'(a)) ? status_of(u, int'(a)) : mreg[u][a];
    endfunction

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input bit es0, input bit es1);
        chk({tag, "/stb_a"},  80'(stb_a),  80'(es0));
        chk({tag, "/stb_b"},  80'(stb_b),  80'(es1));
        chk({tag, "/regs_a"}, regs_a,      exp_regs(0));
        chk({tag, "/regs_b"}, regs_b,      exp_regs(1));
        chk({tag, "/widx_a"}, 80'(widx_a), 80'(midx[0]));
        chk({tag, "/widx_b"}, 80'(widx_b), 80'(midx[1]));
        chk({tag, "/err_a"},  80'(err_a),  80'(merr[0]));
        chk({tag, "/err_b"},  80'(err_b),  80'(merr[1]));
    endtask

    task automatic check_released(input string tag);
        chk({tag, "/rel_a"}, 80'(dbus_a), 80'hFF);
        chk({tag, "/rel_b"}, 80'(dbus_b), 80'hFF);
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < N; i++) mreg[u][i] = 8'h00;
            merr[u] = 1'b0;
            midx[u] = 4'd0;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.CSbar = 1'b1; bus.ALE = 1'b0; bus.Rbar = 1'b1; bus.Wbar = 1'b1; bus.ABUS = '0;
        drv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Leaves the slave in ARMED with the address latched, tb not driving DBUS.
    task automatic addr_phase(input logic [15:0] a);
        @(negedge clk);
        bus.CSbar = 1'b0; bus.ALE = 1'b1; bus.ABUS = a[15:8]; drv = 1'b1; dout = a[7:0];
        @(negedge clk);
        @(negedge clk);
        bus.ALE = 1'b0; drv = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        bit es [2];
        addr_phase(a);
        drv = 1'b1; dout = d ^ 8'hA5; bus.Wbar = 1'b0;
        @(negedge clk);
        dout = d;
        @(negedge clk);
        bus.Wbar = 1'b1; dout = ~d;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            if (a < 16'(N) && !is_ro(u, int'(a))) begin
                mreg[u][a] = d; midx[u] = 4'(a); mstb[u]++; es[u] = 1'b1;
            end else begin
                merr[u] = 1'b1; es[u] = 1'b0;
            end
        end
        check_state($sformatf("wr%0h", a), es[0], es[1]);
        bus.CSbar = 1'b1; drv = 1'b0;
        @(negedge clk);
        check_state($sformatf("wr%0h_after", a), 1'b0, 1'b0);
    endtask

    task automatic do_read(input logic [15:0] a);
        addr_phase(a);
        bus.Rbar = 1'b0;
        #1 check_released($sformatf("rd%0h_lat", a));
        @(negedge clk);
        if (a >= 16'(N)) begin merr[0] = 1'b1; merr[1] = 1'b1; end
        chk($sformatf("rd%0h_a", a), 80'(dbus_a), 80'(exp_read(0, a)));
        chk($sformatf("rd%0h_b", a), 80'(dbus_b), 80'(exp_read(1, a)));
        chk($sformatf("rd%0h_err_a", a), 80'(err_a), 80'(merr[0]));
        chk($sformatf("rd%0h_err_b", a), 80'(err_b), 80'(merr[1]));
        status_b[3*8 +: 8] = 8'($urandom);
        #1 chk($sformatf("rd%0h_live_b", a), 80'(dbus_b), 80'(exp_read(1, a)));
        bus.Rbar = 1'b1;
        #1 check_released($sformatf("rd%0h_rel", a));
        @(negedge clk);
        bus.CSbar = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra;
        logic [7:0]  rd;
        mstb[0] = 0; mstb[1] = 0;
        status_a = {20{4'hC}};
        status_b = {16'h1234, 32'h9ABC_DEF0, 8'h77, 8'h5A, 16'h0F0F};
        apply_reset();
        @(negedge clk);
        check_state("reset", 1'b0, 1'b0);
        check_released("reset");

        for (int i = 0; i < 7; i++) do_write(16'(i), 8'd10);
        do_write(16'd7, 8'hFF);
        do_write(16'd8, 8'd23);
        do_write(16'd9, 8'd33);
        chk("ten_strobes", 80'(seen_a), 80'd10);
        do_read(16'd8);

        do_write(16'd10, 8'd5);
        do_read(16'd12);
        do_read(16'h0103);

        status_b[3*8 +: 8] = 8'h5A;
        do_write(16'd3, 8'd7);
        do_read(16'd3);

        // Abort: CSbar rises while Wbar is still low.
        addr_phase(16'd2);
        drv = 1'b1; dout = 8'd99; bus.Wbar = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.CSbar = 1'b1;
        @(negedge clk);
        bus.Wbar = 1'b1; drv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_state("abort", 1'b0, 1'b0);

        // Reset in the middle of a write.
        addr_phase(16'd2);
        drv = 1'b1; dout = 8'd77; bus.Wbar = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        drv = 1'b0;
        #1 check_state("rst_in_wr", 1'b0, 1'b0);
        check_released("rst_in_wr");
        bus.CSbar = 1'b1; bus.Wbar = 1'b1; rst = 1'b0;
        @(negedge clk);
        do_write(16'd2, 8'd77);

        // Both strobes falling together: no transfer, error flagged.
        addr_phase(16'd1);
        bus.Wbar = 1'b0; bus.Rbar = 1'b0;
        @(negedge clk);
        merr[0] = 1'b1; merr[1] = 1'b1;
        check_state("dual_fall", 1'b0, 1'b0);
        check_released("dual_fall");
        bus.Wbar = 1'b1; bus.Rbar = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_state("dual_fall_after", 1'b0, 1'b0);
        bus.CSbar = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 30; k++) begin
            ra = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(10, 300)) : 16'($urandom_range(0, 9));
            rd = 8'($urandom);
            status_b = {16'($urandom), 32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 1) == 1) do_write(ra, rd);
            else                           do_read(ra);
        end

        @(negedge clk);
        chk("strobe_count_a", 80'(seen_a), 80'(mstb[0]));
        chk("strobe_count_b", 80'(seen_b), 80'(mstb[1]));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/mcu_bus_regfile.md
Name: mcu_bus_regfile

Overview:
- Parametrised slave for the multiplexed microcontroller bus (ABUS/DBUS, ALE, CSbar, Rbar, Wbar).
- Generalises the fixed B0..B6/operand/hour/minute register block to a configurable register count, data width, address width and base address.
- Adds read-back over a tristated DBUS, read-only status registers and a sticky bus-error flag.
- Sits between the external MCU pins and the core datapath and display logic, which consume regs_out.

Parameters:
DATA_W, 8, DBUS width and register width
ABUS_W, 8, ABUS width; full address = {ABUS, DBUS}, ADDR_W = ABUS_W+DATA_W
NUM_REGS, 10, number of registers (>=1)
BASE_ADDR, 0, address of register 0
RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only and sourced from status_in
RESET_VAL, 0, DATA_W-bit reset value of every writable register

Ports:
clock  in  1  system clock; all bus pins sampled on rising edge
reset  in  1  synchronous, active-high reset
ABUS  in  ABUS_W  high address byte(s), valid while ALE=1
DBUS  inout  DATA_W  low address while ALE=1, then data; driven by block only during reads
CSbar  in  1  chip select, active low
ALE  in  1  address latch enable, active high
Rbar  in  1  read strobe, active low
Wbar  in  1  write strobe, active low
status_in  in  NUM_REGS*DATA_W  read values for RO registers; slice i = register i
regs_out  out  NUM_REGS*DATA_W  current register contents; slice i = register i
wr_strobe  out  1  one-cycle pulse after each committed write
wr_index  out  max(1,clog2(NUM_REGS))  index of the register last written
bus_err  out  1  sticky error flag, cleared only by reset

Behaviour:
- Reset, synchronous and active-high, sets:
  - state to IDLE and the latched address to 0;
  - every writable register to RESET_VAL, with RO slices of regs_out following status_in;
  - wr_strobe=0, wr_index=0, bus_err=0 and DBUS released (Z);
  - the previous-strobe registers for Rbar and Wbar to 1.
- Strobe edges: a falling edge means the previous sample was 1 and the current sample is 0. Because the previous-strobe registers reset to 1, a strobe already low out of reset counts as a falling edge.
- FSM states: IDLE, CAPTURE, ARMED, WR, RD.
- CSbar=1 from any state forces IDLE on the next edge. Any write not yet committed is discarded.
- IDLE -> CAPTURE when CSbar=0 and ALE=1.
- CAPTURE:
  - latch addr={ABUS,DBUS} every cycle while ALE=1;
  - ALE=0 -> ARMED, with the last latched address held.
- ARMED:
  - ALE=1 -> CAPTURE (re-address).
  - Wbar falling edge -> WR.
  - Rbar falling edge -> RD.
  - Wbar and Rbar falling on the same edge: no transfer, bus_err set, stay in ARMED.
- WR:
  - sample DBUS into a holding register every cycle Wbar=0.
  - On the first edge with Wbar=1, commit the holding value, i.e. the DBUS value at the last Wbar=0 edge. Then return to ARMED; repeated writes to the same address are allowed.
  - Commit updates regs_out at that edge. wr_strobe=1 for exactly the following cycle and wr_index = target index.
- RD:
  - DBUS driven with register[addr-BASE_ADDR] (RO: status_in slice, sampled live).
  - Output enable = (state==RD) && CSbar==0 && Rbar==0. It is combinational, so the bus is released in the same cycle CSbar or Rbar rises.
  - First driven cycle is the cycle after the Rbar falling edge is sampled (latency 1).
  - Rbar=1 -> ARMED.
- Address decode: index = addr-BASE_ADDR.
  - addr<BASE_ADDR or index>=NUM_REGS: write ignored (no wr_strobe), read drives 0, bus_err set.
  - Write to an RO register: ignored, no wr_strobe, bus_err set.
- Arithmetic: the address compare is unsigned ADDR_W-bit. No wrap-around; BASE_ADDR+NUM_REGS must be <= 2^ADDR_W.
- Writes are never blocked by bus_err; the flag is informational.

Test Plan:
- Reset, then write addrs 0..6 = 10, addr 7 = 0xFF, addr 8 = 23, addr 9 = 33 (one full CS/ALE/Wbar cycle each) -> regs_out slices = 10,10,10,10,10,10,10,255,23,33; ten wr_strobe pulses; wr_index=9 at end; bus_err=0.
- After the above, read addr 8 -> DBUS=23 starting one cycle after Rbar is sampled low; DBUS=Z in the same cycle Rbar rises.
- Write 5 to addr 10 with NUM_REGS=10 -> regs_out unchanged, no wr_strobe, bus_err=1. Read addr 12 -> DBUS=0.
- RO_MASK bit 3 set, status_in slice 3 = 0x5A: write 7 to addr 3 -> ignored, bus_err=1; read addr 3 -> DBUS=0x5A.
- Start a write of 99 to addr 2, raise CSbar while Wbar=0 -> register 2 keeps its old value, no wr_strobe, state IDLE.
- Assert reset while in WR with data 77 -> all writable registers = RESET_VAL, bus_err=0, DBUS=Z. A following legal write of 77 to addr 2 succeeds.
